modexp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `modexp` engine between `NREQ` independent requesters, such as the encrypt and decrypt paths. It accepts a job (m, e, n) from one requester at a time and pulses the engine's `go`. It then waits for `done` and returns the result, tagged with the requester index. It sits between the requester ports and a single `modexp #(WIDTH)` instance, whose `clk`/`rst` it shares.

---
 rtl/modexp_arbiter.sv | 170 +++++++++++++++++
 tb/tb_modexp_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin arbiter/sequencer sharing one modexp engine between NREQ
// requesters. One job is outstanding at a time; the result comes back tagged with the
// requester index.
// Optional build macro: MODEXP_ARB_LOCK_EN lets a requester keep the grant for its next job
// (req_lock), so back-to-back CRT halves are not interleaved with other requesters.
module modexp_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_m,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_e,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_n,
    input  logic [NREQ-1:0]             req_lock,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [WIDTH-1:0]            rsp_result,
    output logic                        rsp_err,
    output logic                        mx_go,
    output logic [WIDTH-1:0]            mx_m,
    output logic [WIDTH-1:0]            mx_e,
    output logic [WIDTH-1:0]            mx_n,
    input  logic [WIDTH-1:0]            mx_result,
    input  logic                        mx_done
);

    localparam int unsigned CW = IDW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           done_q;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [CW-1:0]  idx_sum;
    logic [IDW-1:0] idx;
    logic           done_edge;

`ifdef MODEXP_ARB_LOCK_EN
    logic           lock_q;
`else
    logic           unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Only a fresh rising edge of mx_done counts; a level left over from a previous job is ignored.
    assign done_edge = mx_done && !done_q;

    // Pick the first valid requester at or after ptr, wrapping modulo NREQ; a held lock overrides.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx_sum     = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, ptr} + CW'(i);
            if (idx_sum >= CW'(NREQ)) begin
                idx_sum = idx_sum - CW'(NREQ);
            end
            idx = idx_sum[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
`ifdef MODEXP_ARB_LOCK_EN
        // rsp_id still holds the previous grantee while back in IDLE.
        if (lock_q && req_valid[rsp_id]) begin
            grant_found = 1'b1;
            grant_id    = rsp_id;
        end
`endif
    end

    // Accept pulse is combinational so the requester sees it in the same cycle it is sampled.
    always_comb begin
        req_ready = '0;
        if (state == StIdle && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Registered copy of the engine done level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= mx_done;
        end
    end

    // Sequencer FSM: accept, start the engine, wait for completion, hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            ptr        <= '0;
            mx_go      <= 1'b0;
            mx_m       <= '0;
            mx_e       <= '0;
            mx_n       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
`ifdef MODEXP_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            mx_go <= 1'b0;
            case (state)
                StIdle: begin
`ifdef MODEXP_ARB_LOCK_EN
                    // The lock only survives into the very next IDLE visit.
                    lock_q <= grant_found ? req_lock[grant_id] : 1'b0;
`endif
                    if (grant_found) begin
                        mx_m   <= req_m[grant_id];
                        mx_e   <= req_e[grant_id];
                        mx_n   <= req_n[grant_id];
                        rsp_id <= grant_id;
                        if (req_n[grant_id] < WIDTH'(2)) begin
                            // Degenerate modulus: answer directly, engine untouched.
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_valid  <= 1'b1;
                            state      <= StResp;
                        end else begin
                            rsp_err <= 1'b0;
                            mx_go   <= 1'b1;
                            state   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    state <= StWait;
                end
                StWait: begin
                    if (done_edge) begin
                        rsp_result <= mx_result;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
`ifdef MODEXP_ARB_LOCK_EN
                        if (!lock_q) begin
                            ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                        end
`else
                        ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_arbiter.sv
// tb_modexp_arbiter: directed bench for modexp_arbiter with a behavioural modexp engine and a
// response scoreboard. Honours MODEXP_ARB_LOCK_EN for the expected lock ordering.
module tb_modexp_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned LAT   = 5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_m;
    logic [NREQ-1:0][WIDTH-1:0] req_e;
    logic [NREQ-1:0][WIDTH-1:0] req_n;
    logic [NREQ-1:0]            req_lock;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [0:0]                 rsp_id;
    logic [WIDTH-1:0]           rsp_result;
    logic                       rsp_err;
    logic                       mx_go;
    logic [WIDTH-1:0]           mx_m;
    logic [WIDTH-1:0]           mx_e;
    logic [WIDTH-1:0]           mx_n;
    logic [WIDTH-1:0]           mx_result;
    logic                       mx_done;

    modexp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_m      (req_m),
        .req_e      (req_e),
        .req_n      (req_n),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mx_go      (mx_go),
        .mx_m       (mx_m),
        .mx_e       (mx_e),
        .mx_n       (mx_n),
        .mx_result  (mx_result),
        .mx_done    (mx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]       id;
        logic [WIDTH-1:0] res;
        logic             err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int go_count = 0;
    int stray = 0;
    int multi = 0;

    logic [NREQ-1:0]  s_req_ready;
    logic             s_rsp_valid;
    logic [0:0]       s_rsp_id;
    logic [WIDTH-1:0] s_rsp_result;
    logic             s_rsp_err;
    logic             s_mx_go;
    logic [WIDTH-1:0] s_mx_m;
    logic [WIDTH-1:0] s_mx_e;
    logic [WIDTH-1:0] s_mx_n;

    // Behavioural engine: raises done LAT cycles after go and holds it until the next go.
    function automatic logic [WIDTH-1:0] pow_mod(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                                                 input logic [WIDTH-1:0] n);
        longint unsigned r;
        longint unsigned b;
        r = 1;
        b = longint'(m) % longint'(n);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (e[i]) r = (r * b) % longint'(n);
            b = (b * b) % longint'(n);
        end
        return WIDTH'(r);
    endfunction

    logic             busy;
    int               lat_cnt;
    logic [WIDTH-1:0] em, ee, en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mx_done   <= 1'b0;
            mx_result <= '0;
            busy      <= 1'b0;
            lat_cnt   <= 0;
            em        <= '0;
            ee        <= '0;
            en        <= '0;
        end else if (mx_go) begin
            mx_done <= 1'b0;
            busy    <= 1'b1;
            lat_cnt <= int'(LAT);
            em      <= mx_m;
            ee      <= mx_e;
            en      <= mx_n;
        end else if (busy) begin
            if (lat_cnt == 1) begin
                mx_done   <= 1'b1;
                mx_result <= pow_mod(em, ee, en);
                busy      <= 1'b0;
            end
            lat_cnt <= lat_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [0:0] id, input logic [WIDTH-1:0] res, input logic err);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, score handshakes, return just after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        s_req_ready  = req_ready;
        s_rsp_valid  = rsp_valid;
        s_rsp_id     = rsp_id;
        s_rsp_result = rsp_result;
        s_rsp_err    = rsp_err;
        s_mx_go      = mx_go;
        s_mx_m       = mx_m;
        s_mx_e       = mx_e;
        s_mx_n       = mx_n;
        if (mx_go) go_count++;
        if (req_ready != '0 && rsp_valid) stray++;
        if ($countones(req_ready) > 1) multi++;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(s_req_ready), 32'd0);
        chk({tag, "_mx_go"}, 32'(s_mx_go), 32'd0);
        chk({tag, "_mx_m"}, 32'(s_mx_m), 32'd0);
        chk({tag, "_mx_e"}, 32'(s_mx_e), 32'd0);
        chk({tag, "_mx_n"}, 32'(s_mx_n), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(s_rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(s_rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, 32'(s_rsp_result), 32'd0);
        chk({tag, "_rsp_err"}, 32'(s_rsp_err), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic set_job(input int r, input int m, input int e, input int n);
        req_m[r] = WIDTH'(m);
        req_e[r] = WIDTH'(e);
        req_n[r] = WIDTH'(n);
    endtask

    // Each requester keeps valid high until it has had n0/n1 jobs accepted; runs until all
    // expected responses have been scored.
    task automatic run_jobs(input int r0, input int r1, input string tag);
        int  n0;
        int  n1;
        bit  fin;
        n0  = r0;
        n1  = r1;
        fin = 1'b0;
        req_valid[0] = (n0 > 0);
        req_valid[1] = (n1 > 0);
        for (int c = 0; c < 300 && !fin; c++) begin
            cyc();
            if (s_req_ready[0]) n0--;
            if (s_req_ready[1]) n1--;
            req_valid[0] = (n0 > 0);
            req_valid[1] = (n1 > 0);
            fin = (sb.size() == 0) && (n0 == 0) && (n1 == 0);
        end
        chk({tag, "_complete"}, 32'(fin), 32'd1);
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g0;
        int   st0;
        int   changed;
        int   cnt;
        logic [WIDTH-1:0] held_res;
        logic [0:0]       held_id;

        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_m     = '0;
        req_e     = '0;
        req_n     = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        check_reset("por");
        rst = 1'b0;
        cyc();

        // Single job: 9^3 mod 55 = 14
        set_job(0, 9, 3, 55);
        push_exp(1'b0, 16'd14, 1'b0);
        g0 = go_count;
        req_valid = 2'b01;
        cyc();
        chk("single_accept", 32'(s_req_ready), 32'd1);
        req_valid = 2'b00;
        cyc();
        chk("single_go_t1", 32'(s_mx_go), 32'd1);
        chk("single_mx_m", 32'(s_mx_m), 32'd9);
        chk("single_mx_e", 32'(s_mx_e), 32'd3);
        chk("single_mx_n", 32'(s_mx_n), 32'd55);
        cyc();
        chk("single_go_one_cycle", 32'(s_mx_go), 32'd0);
        run_jobs(0, 0, "single");
        chk("single_go_count", 32'(go_count - g0), 32'd1);

        // Round-robin from reset: order 0,1,0,1 with req0 resubmitting at once
        do_reset();
        set_job(0, 4, 13, 497);
        set_job(1, 2, 10, 1000);
        push_exp(1'b0, 16'd445, 1'b0);
        push_exp(1'b1, 16'd24, 1'b0);
        push_exp(1'b0, 16'd445, 1'b0);
        push_exp(1'b1, 16'd24, 1'b0);
        run_jobs(2, 2, "rr");

        // Reject: n = 1 answers next cycle with err, engine untouched
        set_job(1, 5, 3, 1);
        push_exp(1'b1, 16'd0, 1'b1);
        g0 = go_count;
        req_valid = 2'b10;
        cyc();
        chk("rej_accept", 32'(s_req_ready), 32'd2);
        req_valid = 2'b00;
        cyc();
        chk("rej_rsp_valid_t1", 32'(s_rsp_valid), 32'd1);
        chk("rej_err", 32'(s_rsp_err), 32'd1);
        chk("rej_result", 32'(s_rsp_result), 32'd0);
        cyc();
        chk("rej_rsp_cleared", 32'(s_rsp_valid), 32'd0);
        chk("rej_no_go", 32'(go_count - g0), 32'd0);

        // Backpressure: response held 10 cycles while req1 waits
        rsp_ready = 1'b0;
        set_job(0, 9, 3, 55);
        set_job(1, 2, 10, 1000);
        push_exp(1'b0, 16'd14, 1'b0);
        st0 = stray;
        req_valid = 2'b01;
        cyc();
        chk("bp_accept", 32'(s_req_ready), 32'd1);
        req_valid = 2'b00;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (s_rsp_valid) break;
        end
        chk("bp_rsp_valid", 32'(s_rsp_valid), 32'd1);
        held_res = s_rsp_result;
        held_id  = s_rsp_id;
        chk("bp_held_result", 32'(held_res), 32'd14);
        chk("bp_held_id", 32'(held_id), 32'd0);
        changed = 0;
        req_valid = 2'b10;
        push_exp(1'b1, 16'd24, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (!s_rsp_valid || s_rsp_result !== held_res || s_rsp_id !== held_id) changed++;
        end
        chk("bp_stable", 32'(changed), 32'd0);
        chk("bp_no_ready", 32'(stray - st0), 32'd0);
        rsp_ready = 1'b1;
        run_jobs(0, 1, "bp");

        // Reset three cycles after go aborts the job silently
        set_job(0, 9, 3, 55);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        cyc();
        chk("mid_go", 32'(s_mx_go), 32'd1);
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check_reset("midrst");
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (s_rsp_valid) cnt++;
        end
        chk("midrst_no_rsp", 32'(cnt), 32'd0);
        push_exp(1'b0, 16'd14, 1'b0);
        run_jobs(1, 0, "post_rst");

        // Lock: req0 locked twice vs req1
        do_reset();
        set_job(0, 9, 3, 55);
        set_job(1, 2, 10, 1000);
`ifdef MODEXP_ARB_LOCK_EN
        push_exp(1'b0, 16'd14, 1'b0);
        push_exp(1'b0, 16'd14, 1'b0);
        push_exp(1'b1, 16'd24, 1'b0);
`else
        push_exp(1'b0, 16'd14, 1'b0);
        push_exp(1'b1, 16'd24, 1'b0);
        push_exp(1'b0, 16'd14, 1'b0);
`endif
        req_lock = 2'b01;
        run_jobs(2, 1, "lock");
        req_lock = 2'b00;

        chk("one_grant_per_cycle", 32'(multi), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
